// File: rtl/rf_commit_ctrl_pkg.sv
// rf_commit_ctrl_pkg: shared constants and state encoding for the commit sequencer.
package rf_commit_ctrl_pkg;

  localparam int unsigned ROB_INDEX_BIT    = 4;
  localparam int unsigned FLUSH_CYCLES_DEF = 2;
  localparam int unsigned FLUSH_CNT_W      = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_e;

endpackage

// File: rtl/rf_commit_ctrl_flush_timer.sv
// flush_timer: load/decrement counter that owns the RF clear output.
//   clk_i, rst_n_i : clock, async active-low reset
//   en_i           : global advance enable (low freezes everything)
//   load_i         : arm the timer with load_val_i
//   load_val_i     : number of cycles clear is to be held
//   tick_i         : flush in progress this cycle
//   clear_o        : registered clear
//   busy_o         : flush still has edges to go after this one
module flush_timer
  import rf_commit_ctrl_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   en_i,
  input  logic                   load_i,
  input  logic [FLUSH_CNT_W-1:0] load_val_i,
  input  logic                   tick_i,
  output logic                   clear_o,
  output logic                   busy_o
);

  logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
  logic                   clear_q, clear_d;

  // First flush edge only raises clear; the count then runs down one per
  // edge and the edge that sees cnt==1 drops clear, giving exactly
  // load_val cycles of clear.
  always_comb begin
    cnt_d   = cnt_q;
    clear_d = clear_q;
    if (load_i) begin
      cnt_d   = load_val_i;
      clear_d = 1'b0;
    end else if (tick_i) begin
      if (!clear_q) begin
        clear_d = 1'b1;
      end else if (cnt_q == FLUSH_CNT_W'(1)) begin
        clear_d = 1'b0;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q - FLUSH_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q   <= '0;
      clear_q <= 1'b0;
    end else if (en_i) begin
      cnt_q   <= cnt_d;
      clear_q <= clear_d;
    end
  end

  assign clear_o = clear_q;
  assign busy_o  = (cnt_q != '0) && !(clear_q && (cnt_q == FLUSH_CNT_W'(1)));

endmodule

// File: rtl/rf_commit_ctrl.sv
// rf_commit_ctrl: in-order commit sequencer, ROB head -> RF write/clear port.
//   clk_in, rst_n_in, rdy_in         : clock, async active-low reset, freeze
//   head_*                           : retiring ROB head entry / handshake
//   set_value_id/_value/_rob_id      : registered RF commit write (id 0 = idle)
//   clear, redirect_valid/_pc        : flush and fetch redirect
//   halted                           : sticky halt
//   retired_cnt                      : retire counter, built only with
//                                      `RF_COMMIT_CNT_EN defined, else 0
module rf_commit_ctrl
  import rf_commit_ctrl_pkg::*;
#(
  parameter int unsigned ROB_W        = ROB_INDEX_BIT,
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             head_valid,
  output logic             head_ready,
  input  logic [ROB_W-1:0] head_rob_id,
  input  logic [4:0]       head_rd,
  input  logic [31:0]      head_value,
  input  logic             head_mispredict,
  input  logic [31:0]      head_target,
  input  logic             head_halt,
  output logic [4:0]       set_value_id,
  output logic [31:0]      set_value,
  output logic [ROB_W-1:0] set_value_rob_id,
  output logic             clear,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             halted,
  output logic [63:0]      retired_cnt
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);

  state_e           state_q, state_d;
  logic             accept;
  logic             flush_load;
  logic             flush_busy;
  logic             clear_w;

  logic [4:0]       set_value_id_q;
  logic [31:0]      set_value_q;
  logic [ROB_W-1:0] set_value_rob_id_q;
  logic             redirect_valid_q;
  logic [31:0]      redirect_pc_q;
  logic [31:0]      target_q;
  logic             halted_q;

  assign accept     = head_valid && head_ready;
  // Halt takes precedence over mispredict: no flush is armed.
  assign flush_load = accept && head_mispredict && !head_halt;

  // ---------------- FSM: state register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= RUN;
    else if (rdy_in) state_q <= state_d;
  end

  // ---------------- FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (accept && head_halt)  state_d = HALT;
        else if (flush_load)      state_d = FLUSH;
      end
      FLUSH: begin
        if (!flush_busy)          state_d = RUN;
      end
      HALT:                       state_d = HALT;
      default:                    state_d = RUN;
    endcase
  end

  // ---------------- FSM: outputs
  always_comb begin
    head_ready = (state_q == RUN) && rdy_in;
  end

  flush_timer u_flush_timer (
    .clk_i      (clk_in),
    .rst_n_i    (rst_n_in),
    .en_i       (rdy_in),
    .load_i     (flush_load),
    .load_val_i (FLUSH_LOAD),
    .tick_i     (state_q == FLUSH),
    .clear_o    (clear_w),
    .busy_o     (flush_busy)
  );

  // ---------------- commit write / redirect / halt registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      set_value_id_q     <= '0;
      set_value_q        <= '0;
      set_value_rob_id_q <= '0;
      redirect_valid_q   <= 1'b0;
      redirect_pc_q      <= '0;
      target_q           <= '0;
      halted_q           <= 1'b0;
    end else if (rdy_in) begin
      set_value_id_q <= accept ? head_rd : 5'd0;
      if (accept) begin
        set_value_q        <= head_value;
        set_value_rob_id_q <= head_rob_id;
      end
      if (flush_load) target_q <= head_target;
      // First FLUSH edge is the one where clear has not yet been raised.
      redirect_valid_q <= (state_q == FLUSH) && !clear_w;
      if ((state_q == FLUSH) && !clear_w) redirect_pc_q <= target_q;
      if (accept && head_halt) halted_q <= 1'b1;
    end
  end

`ifdef RF_COMMIT_CNT_EN
  logic [63:0] retired_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) retired_q <= '0;
    else if (rdy_in && accept) retired_q <= retired_q + 64'd1;
  end

  assign retired_cnt = retired_q;
`else
  assign retired_cnt = '0;
`endif

  assign set_value_id     = set_value_id_q;
  assign set_value        = set_value_q;
  assign set_value_rob_id = set_value_rob_id_q;
  assign clear            = clear_w;
  assign redirect_valid   = redirect_valid_q;
  assign redirect_pc      = redirect_pc_q;
  assign halted           = halted_q;

endmodule
